// File: rtl/seg_pkg.sv
`default_nettype none
// ============================================================================
// Module      : seg_pkg
// Description : Shared definitions for the 7-segment scan controller: blank
//               pattern, scan FSM state type and hex-to-segment decoder.
// Revision    : 1.0 - initial release
// ============================================================================
package seg_pkg;

    // All cathodes off (active-low), order {g,f,e,d,c,b,a}
    localparam logic [6:0] SEG_BLANK = 7'h7F;

    // Scan FSM: blanked guard interval, then the driven part of the slot
    typedef enum logic [0:0] {
        GUARD = 1'b0,
        DRIVE = 1'b1
    } scan_state_t;

    // Hex nibble to active-low segments {g,f,e,d,c,b,a}
    function automatic logic [6:0] hex_to_seg(input logic [3:0] nib);
        logic [6:0] s;
        s = SEG_BLANK;
        case (nib)
            4'h0: s = 7'h40;
            4'h1: s = 7'h79;
            4'h2: s = 7'h24;
            4'h3: s = 7'h30;
            4'h4: s = 7'h19;
            4'h5: s = 7'h12;
            4'h6: s = 7'h02;
            4'h7: s = 7'h78;
            4'h8: s = 7'h00;
            4'h9: s = 7'h10;
            4'hA: s = 7'h08;
            4'hB: s = 7'h03;
            4'hC: s = 7'h46;
            4'hD: s = 7'h21;
            4'hE: s = 7'h06;
            4'hF: s = 7'h0E;
        endcase
        return s;
    endfunction

endpackage
`default_nettype wire

// File: rtl/scan_tick_gen.sv
`default_nettype none
// ============================================================================
// Module      : scan_tick_gen
// Description : Free-running divider; tick is high during the last count of
//               each DIV-cycle period.
// Revision    : 1.0 - initial release
// ============================================================================
module scan_tick_gen #(
    parameter int DIV = 5000
) (
    input  logic clk,
    input  logic rst,
    output logic tick
);

    localparam int                 c_CNT_W = (DIV > 1) ? $clog2(DIV) : 1;
    localparam logic [c_CNT_W-1:0] c_LAST  = c_CNT_W'(DIV - 1);
    localparam logic [c_CNT_W-1:0] c_ONE   = c_CNT_W'(1);

    logic [c_CNT_W-1:0] r_cnt;

    // Count 0..DIV-1 and wrap, independent of anything downstream
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cnt <= '0;
        end else if (r_cnt == c_LAST) begin
            r_cnt <= '0;
        end else begin
            r_cnt <= r_cnt + c_ONE;
        end
    end

    assign tick = (r_cnt == c_LAST);

endmodule
`default_nettype wire

// File: rtl/seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : seg_scan_ctrl
// Description : Time-multiplexed common-anode 7-segment scan controller with
//               inter-digit blanking guard, per-digit enable and blink masks.
// Revision    : 1.0 - initial release
// ============================================================================
module seg_scan_ctrl
    import seg_pkg::*;
#(
    parameter int NUM_DIGITS = 4,
    parameter int SCAN_DIV   = 5000,
    parameter int GUARD_CYC  = 16,
    parameter int BLINK_DIV  = 10000
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [4*NUM_DIGITS-1:0]       digits_in,
    input  logic [NUM_DIGITS-1:0]         dp_in,
    input  logic [NUM_DIGITS-1:0]         en_mask,
    input  logic [NUM_DIGITS-1:0]         blink_mask,
    output logic [NUM_DIGITS-1:0]         an,
    output logic [6:0]                    seg,
    output logic                          dp,
    output logic [$clog2(NUM_DIGITS)-1:0] digit_idx,
    output logic                          frame_done,
    output logic                          blink_phase
);

    localparam int c_IDX_W = $clog2(NUM_DIGITS);
    localparam int c_GRD_W = (GUARD_CYC > 1) ? $clog2(GUARD_CYC) : 1;
    localparam int c_BLK_W = (BLINK_DIV > 1) ? $clog2(BLINK_DIV) : 1;

    localparam logic [c_IDX_W-1:0] c_IDX_LAST = c_IDX_W'(NUM_DIGITS - 1);
    localparam logic [c_IDX_W-1:0] c_IDX_ONE  = c_IDX_W'(1);
    localparam logic [c_GRD_W-1:0] c_GRD_LAST = c_GRD_W'(GUARD_CYC - 1);
    localparam logic [c_GRD_W-1:0] c_GRD_ONE  = c_GRD_W'(1);
    localparam logic [c_BLK_W-1:0] c_BLK_LAST = c_BLK_W'(BLINK_DIV - 1);
    localparam logic [c_BLK_W-1:0] c_BLK_ONE  = c_BLK_W'(1);

    logic w_tick;

    scan_tick_gen #(
        .DIV (SCAN_DIV)
    ) u_scan_tick (
        .clk  (clk),
        .rst  (rst),
        .tick (w_tick)
    );

    scan_state_t            r_state,      w_state_nxt;
    logic [c_GRD_W-1:0]     r_guard_cnt,  w_guard_nxt;
    logic [c_IDX_W-1:0]     r_idx,        w_idx_nxt;
    logic [3:0]             r_snap_nib,   w_snap_nib_nxt;
    logic                   r_snap_dp,    w_snap_dp_nxt;
    logic                   r_snap_en,    w_snap_en_nxt;
    logic                   r_snap_blink, w_snap_blink_nxt;
    logic [c_BLK_W-1:0]     r_blink_cnt,  w_blink_cnt_nxt;
    logic                   r_blink_phase, w_phase_nxt;
    logic [NUM_DIGITS-1:0]  r_an,         w_an_nxt;
    logic [6:0]             r_seg,        w_seg_nxt;
    logic                   r_dp,         w_dp_nxt;
    logic                   r_frame_done, w_frame_nxt;
    logic                   w_show;

    // State, snapshot, blink and output registers
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state       <= GUARD;
            r_guard_cnt   <= '0;
            r_idx         <= '0;
            r_snap_nib    <= '0;
            r_snap_dp     <= 1'b0;
            r_snap_en     <= 1'b0;
            r_snap_blink  <= 1'b0;
            r_blink_cnt   <= '0;
            r_blink_phase <= 1'b0;
            r_an          <= '1;
            r_seg         <= SEG_BLANK;
            r_dp          <= 1'b1;
            r_frame_done  <= 1'b0;
        end else begin
            r_state       <= w_state_nxt;
            r_guard_cnt   <= w_guard_nxt;
            r_idx         <= w_idx_nxt;
            r_snap_nib    <= w_snap_nib_nxt;
            r_snap_dp     <= w_snap_dp_nxt;
            r_snap_en     <= w_snap_en_nxt;
            r_snap_blink  <= w_snap_blink_nxt;
            r_blink_cnt   <= w_blink_cnt_nxt;
            r_blink_phase <= w_phase_nxt;
            r_an          <= w_an_nxt;
            r_seg         <= w_seg_nxt;
            r_dp          <= w_dp_nxt;
            r_frame_done  <= w_frame_nxt;
        end
    end

    // Next-state logic; outputs are derived from next-state values so the
    // registered pins line up with the state they describe
    always_comb begin
        w_state_nxt      = r_state;
        w_guard_nxt      = r_guard_cnt;
        w_idx_nxt        = r_idx;
        w_snap_nib_nxt   = r_snap_nib;
        w_snap_dp_nxt    = r_snap_dp;
        w_snap_en_nxt    = r_snap_en;
        w_snap_blink_nxt = r_snap_blink;
        w_blink_cnt_nxt  = r_blink_cnt;
        w_phase_nxt      = r_blink_phase;
        w_frame_nxt      = 1'b0;
        w_an_nxt         = '1;
        w_seg_nxt        = SEG_BLANK;
        w_dp_nxt         = 1'b1;

        // Blink divider counts scan ticks and flips phase on wrap
        if (w_tick) begin
            if (r_blink_cnt == c_BLK_LAST) begin
                w_blink_cnt_nxt = '0;
                w_phase_nxt     = ~r_blink_phase;
            end else begin
                w_blink_cnt_nxt = r_blink_cnt + c_BLK_ONE;
            end
        end

        case (r_state)
            GUARD: begin
                // Ticks cannot legally land here, so they are not looked at
                if (r_guard_cnt == c_GRD_LAST) begin
                    w_state_nxt      = DRIVE;
                    w_guard_nxt      = '0;
                    w_snap_nib_nxt   = digits_in[{r_idx, 2'b00} +: 4];
                    w_snap_dp_nxt    = dp_in[r_idx];
                    w_snap_en_nxt    = en_mask[r_idx];
                    w_snap_blink_nxt = blink_mask[r_idx];
                end else begin
                    w_guard_nxt = r_guard_cnt + c_GRD_ONE;
                end
            end
            DRIVE: begin
                if (w_tick) begin
                    w_state_nxt = GUARD;
                    if (r_idx == c_IDX_LAST) begin
                        w_idx_nxt   = '0;
                        w_frame_nxt = 1'b1;
                    end else begin
                        w_idx_nxt = r_idx + c_IDX_ONE;
                    end
                end
            end
            default: begin
                w_state_nxt = GUARD;
            end
        endcase

        // Blink phase is applied live, the rest comes from the slot snapshot
        w_show = (w_state_nxt == DRIVE) && w_snap_en_nxt &&
                 !(w_snap_blink_nxt && w_phase_nxt);
        if (w_show) begin
            w_an_nxt[w_idx_nxt] = 1'b0;
            w_seg_nxt           = hex_to_seg(w_snap_nib_nxt);
            w_dp_nxt            = ~w_snap_dp_nxt;
        end
    end

    assign an          = r_an;
    assign seg         = r_seg;
    assign dp          = r_dp;
    assign digit_idx   = r_idx;
    assign frame_done  = r_frame_done;
    assign blink_phase = r_blink_phase;

endmodule
`default_nettype wire

// File: tb/tb_seg_scan_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_seg_scan_ctrl
// Description : Self-checking bench for seg_scan_ctrl with a cycle-indexed
//               reference model feeding an expected-output queue.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seg_scan_ctrl;

    localparam int N   = 4;
    localparam int DIV = 8;
    localparam int G   = 2;
    localparam int B   = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [15:0]   digits_in = 16'h4321;
    logic [3:0]    dp_in = 4'h0;
    logic [3:0]    en_mask = 4'hF;
    logic [3:0]    blink_mask = 4'h0;
    logic [3:0]    an;
    logic [6:0]    seg;
    logic          dp;
    logic [1:0]    digit_idx;
    logic          frame_done;
    logic          blink_phase;

    seg_scan_ctrl #(
        .NUM_DIGITS (N),
        .SCAN_DIV   (DIV),
        .GUARD_CYC  (G),
        .BLINK_DIV  (B)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .digits_in   (digits_in),
        .dp_in       (dp_in),
        .en_mask     (en_mask),
        .blink_mask  (blink_mask),
        .an          (an),
        .seg         (seg),
        .dp          (dp),
        .digit_idx   (digit_idx),
        .frame_done  (frame_done),
        .blink_phase (blink_phase)
    );

    always #5 clk = ~clk;

    int          n_checks = 0;
    int          n_fail   = 0;
    int          t        = 0;   // cycle index since last reset release
    logic [15:0] sb [$];

    // Model snapshot of the slot being driven
    logic [3:0]  m_nib = 4'h0;
    logic        m_dp  = 1'b0;
    logic        m_en  = 1'b0;
    logic        m_bl  = 1'b0;

    logic [6:0]  dec_tbl [16] = '{7'h40, 7'h79, 7'h24, 7'h30, 7'h19, 7'h12, 7'h02, 7'h78,
                                  7'h00, 7'h10, 7'h08, 7'h03, 7'h46, 7'h21, 7'h06, 7'h0E};

    // Expected {an, seg, dp, frame_done, digit_idx, blink_phase} for cycle c
    function automatic logic [15:0] model_out(int c);
        int         pos;
        int         idx;
        logic       ph;
        logic       fd;
        logic       show;
        logic [3:0] a;
        logic [6:0] s;
        logic       d;
        pos  = c % DIV;
        idx  = (c / DIV) % N;
        ph   = ((c / (DIV * B)) % 2) == 1;
        fd   = (c > 0) && ((c % (DIV * N)) == 0);
        a    = 4'hF;
        s    = 7'h7F;
        d    = 1'b1;
        show = (pos >= G) && m_en && !(m_bl && ph);
        if (show) begin
            a[idx] = 1'b0;
            s      = dec_tbl[m_nib];
            d      = ~m_dp;
        end
        return {a, s, d, fd, 2'(idx), ph};
    endfunction

    // Push the expectation for the next cycle from the inputs now applied,
    // then advance to the next sampling point
    task automatic step();
        int c;
        int k;
        c = t + 1;
        if ((c % DIV) == G) begin
            k     = (c / DIV) % N;
            m_nib = digits_in[4*k +: 4];
            m_dp  = dp_in[k];
            m_en  = en_mask[k];
            m_bl  = blink_mask[k];
        end
        sb.push_back(model_out(c));
        @(negedge clk);
        t = c;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        @(negedge clk);
        rst = 1'b0;
        t   = 0;
        sb.delete();
    endtask

    task automatic test_reset();
        do_reset();
        n_checks++;
        if (an !== 4'hF) begin
            n_fail++;
            $display("FAIL reset_an got=%h exp=%h", an, 4'hF);
        end
        n_checks++;
        if (seg !== 7'h7F || dp !== 1'b1) begin
            n_fail++;
            $display("FAIL reset_seg_dp got=%h/%b exp=7f/1", seg, dp);
        end
        n_checks++;
        if (frame_done !== 1'b0 || digit_idx !== 2'd0 || blink_phase !== 1'b0) begin
            n_fail++;
            $display("FAIL reset_ctrl got fd=%b idx=%0d ph=%b exp fd=0 idx=0 ph=0",
                     frame_done, digit_idx, blink_phase);
        end
    endtask

    task automatic test_basic();
        logic [15:0] exp_v;
        logic [15:0] obs;
        int          n_fd;
        n_fd = 0;
        for (int i = 0; i < 64; i++) begin
            step();
            exp_v = sb.pop_front();
            obs   = {an, seg, dp, frame_done, digit_idx, blink_phase};
            if (frame_done === 1'b1) n_fd++;
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL basic t=%0d got=%h exp=%h", t, obs, exp_v);
            end
        end
        n_checks++;
        if (n_fd != 2) begin
            n_fail++;
            $display("FAIL basic_frame_count got=%0d exp=2", n_fd);
        end
    endtask

    task automatic test_en_mask();
        logic [15:0] exp_v;
        logic [15:0] obs;
        int          lit2;
        lit2    = 0;
        en_mask = 4'b1011;
        for (int i = 0; i < 64; i++) begin
            step();
            exp_v = sb.pop_front();
            obs   = {an, seg, dp, frame_done, digit_idx, blink_phase};
            if (an[2] === 1'b0) lit2++;
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL en_mask t=%0d got=%h exp=%h", t, obs, exp_v);
            end
        end
        n_checks++;
        if (lit2 != 0) begin
            n_fail++;
            $display("FAIL en_mask_digit2_dark got=%0d lit cycles exp=0", lit2);
        end
        en_mask = 4'hF;
    endtask

    task automatic test_blink();
        logic [15:0] exp_v;
        logic [15:0] obs;
        blink_mask = 4'b0001;
        for (int i = 0; i < 96; i++) begin
            step();
            exp_v = sb.pop_front();
            obs   = {an, seg, dp, frame_done, digit_idx, blink_phase};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL blink t=%0d got=%h exp=%h", t, obs, exp_v);
            end
        end
        blink_mask = 4'h0;
    endtask

    task automatic test_midslot();
        logic [15:0] exp_v;
        logic [15:0] obs;
        int          k;
        k = 0;
        while (k < 64 && !((t % DIV) == 3 && ((t / DIV) % N) == 0)) begin
            step();
            exp_v = sb.pop_front();
            obs   = {an, seg, dp, frame_done, digit_idx, blink_phase};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL midslot_pre t=%0d got=%h exp=%h", t, obs, exp_v);
            end
            k++;
        end
        n_checks++;
        if (k >= 64) begin
            n_fail++;
            $display("FAIL midslot_sync got=timeout exp=digit0 drive");
        end
        digits_in[3:0] = 4'h8;
        for (int i = 0; i < 40; i++) begin
            step();
            exp_v = sb.pop_front();
            obs   = {an, seg, dp, frame_done, digit_idx, blink_phase};
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL midslot t=%0d got=%h exp=%h", t, obs, exp_v);
            end
        end
    endtask

    task automatic test_dp();
        logic [15:0] exp_v;
        logic [15:0] obs;
        int          bad;
        bad       = 0;
        digits_in = 16'hFFFF;
        dp_in     = 4'b0100;
        for (int i = 0; i < 64; i++) begin
            step();
            exp_v = sb.pop_front();
            obs   = {an, seg, dp, frame_done, digit_idx, blink_phase};
            if (dp === 1'b0 && an !== 4'hB) bad++;
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL dp t=%0d got=%h exp=%h", t, obs, exp_v);
            end
        end
        n_checks++;
        if (bad != 0) begin
            n_fail++;
            $display("FAIL dp_only_digit2 got=%0d stray cycles exp=0", bad);
        end
        dp_in     = 4'h0;
        digits_in = 16'h4321;
    endtask

    task automatic test_async_reset();
        logic [15:0] exp_v;
        logic [15:0] obs;
        int          k;
        int          first_t;
        logic [3:0]  first_an;
        k = 0;
        while (k < 64 && !((t % DIV) == 4 && ((t / DIV) % N) == 0)) begin
            step();
            void'(sb.pop_front());
            k++;
        end
        n_checks++;
        if (an !== 4'hE || k >= 64) begin
            n_fail++;
            $display("FAIL async_pre got an=%h exp an=e", an);
        end
        #2;
        rst = 1'b1;
        #1;
        n_checks++;
        if (an !== 4'hF || seg !== 7'h7F || dp !== 1'b1 || frame_done !== 1'b0) begin
            n_fail++;
            $display("FAIL async_reset got an=%h seg=%h dp=%b fd=%b exp an=f seg=7f dp=1 fd=0",
                     an, seg, dp, frame_done);
        end
        @(negedge clk);
        rst = 1'b0;
        t   = 0;
        sb.delete();
        first_t  = -1;
        first_an = 4'hF;
        for (int i = 0; i < 24; i++) begin
            step();
            exp_v = sb.pop_front();
            obs   = {an, seg, dp, frame_done, digit_idx, blink_phase};
            if (first_t < 0 && an !== 4'hF) begin
                first_t  = t;
                first_an = an;
            end
            n_checks++;
            if (obs !== exp_v) begin
                n_fail++;
                $display("FAIL post_reset t=%0d got=%h exp=%h", t, obs, exp_v);
            end
        end
        n_checks++;
        if (first_t != G || first_an !== 4'hE) begin
            n_fail++;
            $display("FAIL post_reset_first_slot got t=%0d an=%h exp t=%0d an=e",
                     first_t, first_an, G);
        end
    endtask

    initial begin
        test_reset();
        test_basic();
        test_en_mask();
        test_blink();
        test_midslot();
        test_dp();
        test_async_reset();
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog expired");
    end

endmodule
`default_nettype wire

// File: doc/seg_scan_ctrl.md
Name: seg_scan_ctrl

Overview:
Time-multiplexed scan controller for the alarm clock's common-anode 7-segment display. It contains its own scan-tick divider and steps a one-hot active-low anode through NUM_DIGITS positions. Between digits it inserts a blanking guard interval to prevent ghosting. It also decodes each digit's hex nibble to active-low segments, applies per-digit enable and blink masks, and sits between the time/alarm display formatter and the board pins.

Parameters:
NUM_DIGITS, 4, number of multiplexed digits (2..8)
SCAN_DIV, 5000, clk cycles per scan tick (time slot per digit); must be > GUARD_CYC + 1
GUARD_CYC, 16, clk cycles of all-anodes-off blanking after each digit switch; must be >= 1
BLINK_DIV, 10000, scan ticks per blink half-period

Ports:
clk  input  1  system clock
rst  input  1  asynchronous, active-high reset
digits_in  input  4*NUM_DIGITS  hex nibble per digit; digit i = [4i+3:4i]
dp_in  input  NUM_DIGITS  decimal point request per digit, active-high
en_mask  input  NUM_DIGITS  1 = digit displayed, 0 = slot kept but dark
blink_mask  input  NUM_DIGITS  1 = digit blanked during blink phase 1
an  output  NUM_DIGITS  anode drive, active-low, at most one bit low
seg  output  7  cathodes {g,f,e,d,c,b,a}, active-low
dp  output  1  decimal point cathode, active-low
digit_idx  output  $clog2(NUM_DIGITS)  index of current slot
frame_done  output  1  one-cycle pulse when idx wraps NUM_DIGITS-1 -> 0
blink_phase  output  1  current blink phase

Behaviour:
- Reset (async assert, takes effect immediately): tick counter=0, idx=0, state=GUARD, guard counter=0, blink counter=0, blink_phase=0, an=all 1, seg=7'h7F, dp=1, frame_done=0.
- Tick counter: free-running 0..SCAN_DIV-1. tick is asserted combinationally when count==SCAN_DIV-1; count wraps to 0 on the next edge. The counter is independent of the FSM.
- FSM states: GUARD, DRIVE. All outputs are registered.
- GUARD: an=all 1, seg=7'h7F, dp=1. The guard counter increments each cycle. When it reaches GUARD_CYC-1: go to DRIVE, clear the guard counter, and snapshot digits_in[idx], dp_in[idx], en_mask[idx] and blink_mask[idx]. The snapshot prevents tearing if inputs change mid-slot.
- DRIVE: seg=decode(snapshot nibble), dp=~snapshot dp. an[idx]=0 if snap_en && !(snap_blink && blink_phase), otherwise an stays all 1 and seg/dp are forced to 1.
- A tick in DRIVE moves the FSM to GUARD on the next edge. On that edge idx becomes (idx==NUM_DIGITS-1) ? 0 : idx+1, and frame_done=1 for exactly that cycle if idx wrapped.
- Because SCAN_DIV > GUARD_CYC+1, no tick can occur in GUARD. A tick arriving in GUARD (parameter violation) is ignored.
- Every slot lasts exactly SCAN_DIV cycles: GUARD_CYC blanked cycles plus SCAN_DIV-GUARD_CYC driven cycles. This holds for the first slot after reset too, up to tick alignment. Disabled digits still consume their slot, so brightness stays uniform.
- Blink: the blink counter counts ticks 0..BLINK_DIV-1. On a tick at BLINK_DIV-1 it wraps and toggles blink_phase. blink_phase is applied live in DRIVE, not snapshotted, so a toggle can blank or unblank mid-slot.
- Decode (active-low, gfedcba):
  0=40, 1=79, 2=24, 3=30, 4=19, 5=12, 6=02, 7=78,
  8=00, 9=10, A=08, b=03, C=46, d=21, E=06, F=0E (hex).
- Invariant: an never has more than one bit low, and is never low during GUARD.

Decomposition:
- Shared package seg_pkg:
  - SEG_BLANK=7'h7F constant
  - hex-to-segment lookup function/constant array
  - FSM state typedef {GUARD, DRIVE}
- Sub-module scan_tick_gen: parameter DIV, ports clk, rst, tick. It holds the free-running divider, and one instance is used for the scan tick.
- The blink divider stays inline.

Test Plan:
Bench parameters: NUM_DIGITS=4, SCAN_DIV=8, GUARD_CYC=2, BLINK_DIV=4.
- Reset then run: digits_in=16'h4321, all masks enabled -> an sequence E,D,B,7 repeating, each low for 6 cycles preceded by 2 cycles of F; seg=79,24,30,19; frame_done pulses every 32 cycles on idx 3->0.
- en_mask=4'b1011 -> digit 2 slot has an=F and seg=7F for the full 8 cycles; other digits unchanged; slot timing unchanged.
- blink_mask=4'b0001 -> digit 0 dark while blink_phase=1; blink_phase toggles every 32 cycles; digits 1-3 unaffected.
- Change digits_in[3:0] from 1 to 8 mid-DRIVE of digit 0 -> seg stays 79 until that slot ends; next digit-0 slot shows 00.
- dp_in=4'b0100, digits=16'hFFFF -> dp=0 only while an=B; seg=0E in every driven slot.
- Assert rst mid-DRIVE, async between edges -> an=F, seg=7F, dp=1 immediately; after release, first driven slot is idx 0.
